// File: rtl/dcp_pkg.sv
// ----------------------------------------------------------------------------
// dcp_pkg
// Shared definitions for the dcp descriptor header builder.
//   - field widths (MAC, buffer address, port tag, sequence, header word)
//   - default sync byte placed in word0[31:24]
//   - FSM state encoding and header word-index constants
//   - helpers for the word-state walk (IDLE -> W0 -> W1 -> W2 [-> W3] -> GAP)
// Optional feature macro: DCP_HDR_CSUM_EN (adds the checksum word W3).
// ----------------------------------------------------------------------------
package dcp_pkg;

    localparam int unsigned MAC_W  = 48;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned PORT_W = 5;
    localparam int unsigned SEQ_W  = 16;
    localparam int unsigned HDR_W  = 32;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_W1   = 3'd2,
        ST_W2   = 3'd3,
        ST_W3   = 3'd4,
        ST_GAP  = 3'd5
    } dcp_state_e;

    localparam int unsigned WORD0 = 0;
    localparam int unsigned WORD1 = 1;
    localparam int unsigned WORD2 = 2;
`ifdef DCP_HDR_CSUM_EN
    localparam int unsigned WORD3     = 3;
    localparam int unsigned HDR_WORDS = 4;
    localparam dcp_state_e  ST_LAST   = ST_W3;
`else
    localparam int unsigned HDR_WORDS = 3;
    localparam dcp_state_e  ST_LAST   = ST_W2;
`endif

    // True in every state that drives a header word onto the bus.
    function automatic logic is_word_state(input dcp_state_e s);
        return (s == ST_W0) || (s == ST_W1) || (s == ST_W2) || (s == ST_W3);
    endfunction

    // Successor of a word state once its hold time has elapsed.
    function automatic dcp_state_e next_word_state(input dcp_state_e s);
        dcp_state_e n;
        n = ST_GAP;
        case (s)
            ST_W0:   n = ST_W1;
            ST_W1:   n = ST_W2;
`ifdef DCP_HDR_CSUM_EN
            ST_W2:   n = ST_W3;
`endif
            default: n = ST_GAP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dcp_header_builder_if.sv
// ----------------------------------------------------------------------------
// dcp_header_builder_if
// Descriptor request handshake plus the serial header bus toward the dcp.
//   req_valid/req_ready      : descriptor handshake (valid/ready)
//   req_dmac/start_addr/port : descriptor payload, meaningful only on transfer
//   header_o/valid/last      : serial header words
//   busy, seq_o              : status
// Handshake: a descriptor transfers on any cycle where req_valid and
// req_ready are both high; the requester keeps req_valid and the payload
// stable until that cycle, and payload is ignored on all other cycles.
// slave = builder side, master = requester/observer side.
// ----------------------------------------------------------------------------
interface dcp_header_builder_if;

    logic                          req_valid;
    logic                          req_ready;
    logic [dcp_pkg::MAC_W-1:0]     req_dmac;
    logic [dcp_pkg::ADDR_W-1:0]    req_start_addr;
    logic [dcp_pkg::PORT_W-1:0]    req_port;
    logic [dcp_pkg::HDR_W-1:0]     header_o;
    logic                          header_valid;
    logic                          header_last;
    logic                          busy;
    logic [dcp_pkg::SEQ_W-1:0]     seq_o;

    modport master (
        output req_valid, req_dmac, req_start_addr, req_port,
        input  req_ready, header_o, header_valid, header_last, busy, seq_o
    );

    modport slave (
        input  req_valid, req_dmac, req_start_addr, req_port,
        output req_ready, header_o, header_valid, header_last, busy, seq_o
    );

endinterface

// File: rtl/dcp_hdr_word_mux.sv
// ----------------------------------------------------------------------------
// dcp_hdr_word_mux
// Combinational header word selection from the FSM state and the captured
// descriptor. Drives zero outside the word states so the bus idles at 0.
//   state_i  : current builder state
//   dmac_i   : captured destination MAC
//   addr_i   : captured buffer start address
//   port_i   : captured destination port tag
//   seq_i    : sequence number captured at acceptance
//   header_o : selected header word
// Optional feature macro: DCP_HDR_CSUM_EN (W3 = W0 ^ W1 ^ W2).
// ----------------------------------------------------------------------------
module dcp_hdr_word_mux
    import dcp_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  dcp_state_e        state_i,
    input  logic [MAC_W-1:0]  dmac_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [PORT_W-1:0] port_i,
    input  logic [SEQ_W-1:0]  seq_i,
    output logic [HDR_W-1:0]  header_o
);

    logic [HDR_W-1:0] words [HDR_WORDS];

    assign words[WORD0] = {SYNC_BYTE, 3'b000, port_i, seq_i};
    assign words[WORD1] = dmac_i[47:16];
    assign words[WORD2] = {dmac_i[15:0], addr_i};
`ifdef DCP_HDR_CSUM_EN
    assign words[WORD3] = words[WORD0] ^ words[WORD1] ^ words[WORD2];
`endif

    always_comb begin
        header_o = '0;
        case (state_i)
            ST_W0:   header_o = words[WORD0];
            ST_W1:   header_o = words[WORD1];
            ST_W2:   header_o = words[WORD2];
`ifdef DCP_HDR_CSUM_EN
            ST_W3:   header_o = words[WORD3];
`endif
            default: header_o = '0;
        endcase
    end

endmodule

// File: rtl/dcp_header_builder.sv
// ----------------------------------------------------------------------------
// dcp_header_builder
// Accepts one frame descriptor per handshake and serialises it as a fixed
// header sequence W0 (sync/port/seq), W1 (DMAC[47:16]), W2 (DMAC[15:0],
// start_addr), each word held HOLD_CYCLES, followed by GAP_CYCLES idle
// cycles before the next descriptor can be accepted.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : descriptor handshake, header bus, busy, seq_o
//   dbg_state_o  : current FSM state for observation
// Optional feature macro: DCP_HDR_CSUM_EN (fourth checksum word W3).
// ----------------------------------------------------------------------------
module dcp_header_builder
    import dcp_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    dcp_header_builder_if.slave  bus,
    output dcp_state_e           dbg_state_o
);

    // Hold/gap counter runs 0..N-1 inside each timed state.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    dcp_state_e        state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [SEQ_W-1:0]  seq_o_q;
    logic [MAC_W-1:0]  cap_dmac_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [PORT_W-1:0] cap_port_q;
    logic [SEQ_W-1:0]  cap_seq_q;
    logic              accept;

    // Ready only in IDLE, so at most one descriptor is ever held.
    assign accept = bus.req_valid && (state_q == ST_IDLE);
    assign seq_d  = seq_q + 16'd1;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_W0;
                    hold_d  = '0;
                end
            end
            ST_W0, ST_W1, ST_W2, ST_W3: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = next_word_state(state_q);
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (hold_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            seq_q      <= '0;
            seq_o_q    <= '0;
            cap_dmac_q <= '0;
            cap_addr_q <= '0;
            cap_port_q <= '0;
            cap_seq_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (accept) begin
                cap_dmac_q <= bus.req_dmac;
                cap_addr_q <= bus.req_start_addr;
                cap_port_q <= bus.req_port;
                // The current counter value goes into this header; seq_o
                // changes on the same edge that enters W0.
                cap_seq_q  <= seq_q;
                seq_o_q    <= seq_q;
                seq_q      <= seq_d;
            end
        end
    end

    dcp_hdr_word_mux #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_word_mux (
        .state_i  (state_q),
        .dmac_i   (cap_dmac_q),
        .addr_i   (cap_addr_q),
        .port_i   (cap_port_q),
        .seq_i    (cap_seq_q),
        .header_o (bus.header_o)
    );

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.header_valid = is_word_state(state_q);
    assign bus.header_last  = (state_q == ST_LAST);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.seq_o        = seq_o_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_dcp_header_builder.sv
// ----------------------------------------------------------------------------
// tb_dcp_header_builder
// Two builders share one clock: u_a (HOLD=1, GAP=2) and u_b (HOLD=3, GAP=2).
// Every cycle after an acceptance is predicted from the descriptor and the
// header format: {ready, busy, valid, last, seq_o, header_o}.
// ----------------------------------------------------------------------------
module tb_dcp_header_builder;
    import dcp_pkg::*;

    localparam int         HOLD_A = 1;
    localparam int         HOLD_B = 3;
    localparam int         GAP    = 2;
    localparam logic [7:0] SYNC   = 8'hA5;
`ifdef DCP_HDR_CSUM_EN
    localparam int         NWORDS = 4;
`else
    localparam int         NWORDS = 3;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    dcp_header_builder_if if_a ();
    dcp_header_builder_if if_b ();
    dcp_state_e dbg_a, dbg_b;

    dcp_header_builder #(.HOLD_CYCLES(HOLD_A), .GAP_CYCLES(GAP), .SYNC_BYTE(SYNC)) u_a (
        .clk(clk), .reset(rst_a), .bus(if_a), .dbg_state_o(dbg_a));
    dcp_header_builder #(.HOLD_CYCLES(HOLD_B), .GAP_CYCLES(GAP), .SYNC_BYTE(SYNC)) u_b (
        .clk(clk), .reset(rst_b), .bus(if_b), .dbg_state_o(dbg_b));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [51:0] exp_a_q[$];
    logic [51:0] exp_b_q[$];
    logic [15:0] model_seq [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [51:0] mk(input logic r, input logic b, input logic v,
                                       input logic l, input logic [15:0] s,
                                       input logic [31:0] h);
        return {r, b, v, l, s, h};
    endfunction

    function automatic logic [51:0] obs_of(input int sel);
        if (sel == 0)
            return {if_a.req_ready, if_a.busy, if_a.header_valid, if_a.header_last,
                    if_a.seq_o, if_a.header_o};
        return {if_b.req_ready, if_b.busy, if_b.header_valid, if_b.header_last,
                if_b.seq_o, if_b.header_o};
    endfunction

    always @(negedge clk) begin
        if (exp_a_q.size() > 0) check("dut_a_cycle", 64'(obs_of(0)), 64'(exp_a_q.pop_front()));
        if (exp_b_q.size() > 0) check("dut_b_cycle", 64'(obs_of(1)), 64'(exp_b_q.pop_front()));
    end

    task automatic push(input int sel, input logic [51:0] e);
        if (sel == 0) exp_a_q.push_back(e);
        else          exp_b_q.push_back(e);
    endtask

    // Reference: the full cycle-by-cycle picture of one header from W0 onward.
    task automatic push_header(input int sel, input logic [47:0] dmac, input logic [15:0] addr,
                               input logic [4:0] port, input logic [15:0] s);
        logic [31:0] w [4];
        int hold;
        w[0] = {SYNC, 3'b000, port, s};
        w[1] = dmac[47:16];
        w[2] = {dmac[15:0], addr};
        w[3] = w[0] ^ w[1] ^ w[2];
        hold = (sel == 0) ? HOLD_A : HOLD_B;
        for (int i = 0; i < NWORDS; i++)
            for (int h = 0; h < hold; h++)
                push(sel, mk(1'b0, 1'b1, 1'b1, (i == NWORDS - 1), s, w[i]));
        for (int g = 0; g < GAP; g++)
            push(sel, mk(1'b0, 1'b1, 1'b0, 1'b0, s, 32'h0));
        push(sel, mk(1'b1, 1'b0, 1'b0, 1'b0, s, 32'h0));
    endtask

    // ---------------- driver ----------------
    task automatic drive_req(input int sel, input logic v, input logic [47:0] dmac,
                             input logic [15:0] addr, input logic [4:0] port);
        if (sel == 0) begin
            if_a.req_valid = v; if_a.req_dmac = dmac; if_a.req_start_addr = addr; if_a.req_port = port;
        end else begin
            if_b.req_valid = v; if_b.req_dmac = dmac; if_b.req_start_addr = addr; if_b.req_port = port;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? if_a.req_ready : if_b.req_ready;
    endfunction

    // Returns with ok=1 just after the accepting edge; valid stays high if keep.
    task automatic wait_accept(input int sel, input logic [47:0] dmac, input logic [15:0] addr,
                               input logic [4:0] port, output bit ok);
        int n;
        @(negedge clk);
        drive_req(sel, 1'b1, dmac, addr, port);
        n = 0;
        while (!rdy(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 200);
        if (!ok) begin
            check("ready_timeout", 64'(rdy(sel)), 64'd1);
            drive_req(sel, 1'b0, dmac, addr, port);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int sel, input logic [47:0] dmac, input logic [15:0] addr,
                        input logic [4:0] port, input bit keep);
        bit ok;
        wait_accept(sel, dmac, addr, port, ok);
        if (ok) begin
            push_header(sel, dmac, addr, port, model_seq[sel]);
            model_seq[sel] = model_seq[sel] + 16'd1;
            if (!keep) drive_req(sel, 1'b0, dmac, addr, port);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a_q.size() > 0 || exp_b_q.size() > 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_a_q.size() + exp_b_q.size()), 64'd0);
    endtask

    // Header on u_a interrupted by reset while W1 is on the bus.
    task automatic reset_mid_header(input logic [47:0] dmac, input logic [15:0] addr,
                                    input logic [4:0] port);
        logic [31:0] w0;
        bit ok;
        wait_accept(0, dmac, addr, port, ok);
        if (ok) begin
            w0 = {SYNC, 3'b000, port, model_seq[0]};
            push(0, mk(1'b0, 1'b1, 1'b1, 1'b0, model_seq[0], w0));
            push(0, mk(1'b0, 1'b1, 1'b1, 1'b0, model_seq[0], dmac[47:16]));
            push(0, mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0));
            drive_req(0, 1'b0, dmac, addr, port);
            model_seq[0] = 16'h0;
            @(negedge clk);          // W0 on the bus
            @(negedge clk);          // W1 on the bus
            rst_a = 1'b1;
            @(negedge clk);
            rst_a = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int sel;
        bit keep;
        model_seq[0] = 16'h0;
        model_seq[1] = 16'h0;
        drive_req(0, 1'b0, 48'h0, 16'h0, 5'h0);
        drive_req(1, 1'b0, 48'h0, 16'h0, 5'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_a", 64'(obs_of(0)), 64'(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0)));
        check("reset_b", 64'(obs_of(1)), 64'(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0)));
        check("reset_state_a", 64'(dbg_a), 64'(ST_IDLE));
        rst_a = 1'b0;
        rst_b = 1'b0;

        // First header straight after reset, with a second one queued behind it.
        send(0, 48'haa2030405060, 16'h0100, 5'd1, 1'b1);
        send(0, 48'h123456789abc, 16'hbeef, 5'd7, 1'b0);
        drain();

        // Abandoned header, then the checksum reference descriptor at seq 0.
        reset_mid_header(48'h0badc0ffee01, 16'h4242, 5'd3);
        send(0, 48'hffccbb440011, 16'h0020, 5'd2, 1'b0);
        drain();

        // Long hold: back-to-back pair on u_b.
        send(1, 48'h010203040506, 16'h0708, 5'd9, 1'b1);
        send(1, 48'hfedcba987654, 16'h3210, 5'd31, 1'b0);
        drain();

        // Sequence wrap through a backdoor preload while u_a is idle.
        @(negedge clk);
        force u_a.seq_q = 16'hFFFF;
        @(negedge clk);
        release u_a.seq_q;
        model_seq[0] = 16'hFFFF;
        send(0, 48'h111122223333, 16'h4444, 5'd5, 1'b1);
        send(0, 48'h555566667777, 16'h8888, 5'd6, 1'b0);
        drain();

        // Random traffic on both builders.
        sel  = 0;
        keep = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!keep) sel = int'($urandom_range(0, 1));
            keep = (i < 23) ? bit'($urandom_range(0, 1)) : 1'b0;
            send(sel, {$urandom(), 16'($urandom())}, 16'($urandom()),
                 5'($urandom_range(0, 31)), keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
